// File: rtl/ball_ctrl.sv
// Game sequencer for the ball position datapath: step strobe, serve/move enable,
// direction bits, bounce/hit/miss resolution, scoring and endgame.
module ball_ctrl #(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int TICK_DIV     = 1024,
  parameter int PADDLE_LEN   = 3,
  parameter int SCORE_W      = 2,
  parameter int WIN_SCORE    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIT_OF_WIDTH-1:0] ball_x,
  input  logic [BIT_OF_WIDTH-1:0] ball_y,
  input  logic [BIT_OF_WIDTH-1:0] pad_l_y,
  input  logic [BIT_OF_WIDTH-1:0] pad_r_y,
  output logic                    step,
  output logic                    en,
  output logic                    x_dir,
  output logic                    y_dir,
  output logic [SCORE_W-1:0]      score_l,
  output logic [SCORE_W-1:0]      score_r,
  output logic                    endgame,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]           TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BIT_OF_WIDTH-1:0] X_LEFT    = BIT_OF_WIDTH'(1);
  localparam logic [BIT_OF_WIDTH-1:0] X_RIGHT   = BIT_OF_WIDTH'(WIDTH - 2);
  localparam logic [BIT_OF_WIDTH-1:0] Y_MAX     = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [BIT_OF_WIDTH:0]   PAD_SPAN  = (BIT_OF_WIDTH + 1)'(PADDLE_LEN - 1);
  localparam logic [SCORE_W-1:0]      WIN       = SCORE_W'(WIN_SCORE);

  state_t              r_state,   w_state_nx;
  logic [TW-1:0]       r_tick,    w_tick_nx;
  logic                r_step,    w_step_nx;
  logic                r_en,      w_en_nx;
  logic                r_x_dir,   w_x_dir_nx;
  logic                r_y_dir,   w_y_dir_nx;
  logic [SCORE_W-1:0]  r_score_l, w_score_l_nx;
  logic [SCORE_W-1:0]  r_score_r, w_score_r_nx;
  logic                r_endgame, w_endgame_nx;
  logic                w_wrap, w_miss_l, w_miss_r;

  // Extended by one bit so a paddle near the bottom edge never wraps to row 0.
  function automatic logic on_paddle(input logic [BIT_OF_WIDTH-1:0] y,
                                     input logic [BIT_OF_WIDTH-1:0] pad);
    logic [BIT_OF_WIDTH:0] y_e, p_e;
    y_e = {1'b0, y};
    p_e = {1'b0, pad};
    return (y_e >= p_e) && (y_e <= p_e + PAD_SPAN);
  endfunction

  assign w_wrap = (r_tick == TICK_LAST);

  always_comb begin
    // NOTE: every comb output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    w_state_nx   = r_state;
    w_tick_nx    = '0;
    w_step_nx    = 1'b0;
    w_en_nx      = 1'b0;
    w_x_dir_nx   = r_x_dir;
    w_y_dir_nx   = r_y_dir;
    w_score_l_nx = r_score_l;
    w_score_r_nx = r_score_r;
    w_endgame_nx = 1'b0;
    w_miss_l     = 1'b0;
    w_miss_r     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = S_SERVE;
      end

      S_SERVE: begin
        if (w_wrap) begin
          w_state_nx = S_PLAY;
          w_step_nx  = 1'b1;
        end else begin
          w_tick_nx = r_tick + TW'(1);
        end
      end

      S_PLAY: begin
        w_en_nx = 1'b1;
        if (!w_wrap) begin
          w_tick_nx = r_tick + TW'(1);
        end else begin
          if (ball_y == '0 && r_y_dir)     w_y_dir_nx = 1'b0;
          if (ball_y == Y_MAX && !r_y_dir) w_y_dir_nx = 1'b1;
          if (ball_x == X_LEFT && r_x_dir) begin
            if (on_paddle(ball_y, pad_l_y)) w_x_dir_nx = 1'b0;
            else                            w_miss_l   = 1'b1;
          end
          if (ball_x == X_RIGHT && !r_x_dir) begin
            if (on_paddle(ball_y, pad_r_y)) w_x_dir_nx = 1'b1;
            else                            w_miss_r   = 1'b1;
          end
          if (w_miss_l) begin
            w_score_r_nx = r_score_r + SCORE_W'(1);
            w_state_nx   = S_POINT;
            w_en_nx      = 1'b0;
          end else if (w_miss_r) begin
            w_score_l_nx = r_score_l + SCORE_W'(1);
            w_state_nx   = S_POINT;
            w_en_nx      = 1'b0;
          end else begin
            w_step_nx = 1'b1;
          end
        end
      end

      S_POINT: begin
        if (r_score_l == WIN || r_score_r == WIN) begin
          w_state_nx   = S_OVER;
          w_endgame_nx = 1'b1;
        end else begin
          // A miss leaves x_dir pointing at the conceding side, which is the serve direction.
          w_state_nx = S_SERVE;
          w_y_dir_nx = 1'b0;
        end
      end

      S_OVER: begin
        w_endgame_nx = 1'b1;
        if (start) begin
          w_state_nx   = S_SERVE;
          w_endgame_nx = 1'b0;
          w_score_l_nx = '0;
          w_score_r_nx = '0;
          w_x_dir_nx   = 1'b0;
          w_y_dir_nx   = 1'b0;
        end
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_step    <= 1'b0;
      r_en      <= 1'b0;
      r_x_dir   <= 1'b0;
      r_y_dir   <= 1'b0;
      r_score_l <= '0;
      r_score_r <= '0;
      r_endgame <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_tick    <= w_tick_nx;
      r_step    <= w_step_nx;
      r_en      <= w_en_nx;
      r_x_dir   <= w_x_dir_nx;
      r_y_dir   <= w_y_dir_nx;
      r_score_l <= w_score_l_nx;
      r_score_r <= w_score_r_nx;
      r_endgame <= w_endgame_nx;
    end
  end

  assign step    = r_step;
  assign en      = r_en;
  assign x_dir   = r_x_dir;
  assign y_dir   = r_y_dir;
  assign score_l = r_score_l;
  assign score_r = r_score_r;
  assign endgame = r_endgame;
  assign state   = r_state;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl with TICK_DIV=4 on an 8x8 field, 3-cell paddles,
// first to 3 points wins.
module tb_ball_ctrl;

  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [BW-1:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic          step, en, x_dir, y_dir, endgame;
  logic [1:0]    score_l, score_r;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  ball_ctrl #(
    .WIDTH(8), .BIT_OF_WIDTH(BW), .TICK_DIV(4), .PADDLE_LEN(3), .SCORE_W(2), .WIN_SCORE(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .step(step), .en(en), .x_dir(x_dir), .y_dir(y_dir),
    .score_l(score_l), .score_r(score_r), .endgame(endgame), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t expected < 100000", $time);
    $fatal(1);
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_period();
    repeat (4) tick_clk();
  endtask

  task automatic set_ball(input int bx, input int by, input int pl, input int pr);
    ball_x  = BW'(bx);
    ball_y  = BW'(by);
    pad_l_y = BW'(pl);
    pad_r_y = BW'(pr);
  endtask

  task automatic wait_step(input string tag);
    int n = 0;
    do begin
      tick_clk();
      n++;
    end while (step !== 1'b1 && n < 12);
    checks++;
    if (step !== 1'b1) begin
      errors++;
      $display("FAIL %s: step=%b after %0d cycles, expected 1", tag, step, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    set_ball(4, 3, 0, 0);
    repeat (2) tick_clk();
    rst = 1'b0;
    checks++;
    if ({state, step, en, endgame} !== 6'b000_000) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d step=%b en=%b endgame=%b, expected 0 0 0 0", state, step, en, endgame);
    end
    checks++;
    if ({x_dir, y_dir, score_l, score_r} !== 6'b0) begin
      errors++;
      $display("FAIL reset_data: x=%b y=%b sl=%0d sr=%0d, expected all 0", x_dir, y_dir, score_l, score_r);
    end
    tick_clk();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d expected 0", state);
    end
  endtask

  task automatic test_serve();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    checks++;
    if ({state, en, step} !== {3'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL serve_enter: state=%0d en=%b step=%b, expected 1 0 0", state, en, step);
    end
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      checks++;
      if ({state, step} !== {3'd1, 1'b0}) begin
        errors++;
        $display("FAIL serve_wait%0d: state=%0d step=%b, expected 1 0", i, state, step);
      end
    end
    tick_clk();
    checks++;
    if ({state, step, en} !== {3'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL serve_load: state=%0d step=%b en=%b, expected 2 1 0", state, step, en);
    end
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      checks++;
      if ({step, en} !== 2'b01) begin
        errors++;
        $display("FAIL play_gap%0d: step=%b en=%b, expected 0 1", i, step, en);
      end
    end
    tick_clk();
    checks++;
    if ({step, en, x_dir, y_dir} !== 4'b1100) begin
      errors++;
      $display("FAIL play_step: step=%b en=%b x=%b y=%b, expected 1 1 0 0", step, en, x_dir, y_dir);
    end
  endtask

  task automatic test_y_bounce();
    set_ball(4, 7, 0, 0);
    run_period();
    checks++;
    if ({step, x_dir, y_dir} !== 3'b101) begin
      errors++;
      $display("FAIL bounce_bottom: step=%b x=%b y=%b, expected 1 0 1", step, x_dir, y_dir);
    end
    set_ball(4, 0, 0, 0);
    tick_clk();
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL step_single: step=%b expected 0", step);
    end
    repeat (3) tick_clk();
    checks++;
    if ({step, x_dir, y_dir} !== 3'b100) begin
      errors++;
      $display("FAIL bounce_top: step=%b x=%b y=%b, expected 1 0 0", step, x_dir, y_dir);
    end
  endtask

  task automatic test_left_hit();
    set_ball(6, 3, 0, 2);
    run_period();
    checks++;
    if ({step, x_dir} !== 2'b11) begin
      errors++;
      $display("FAIL right_hit: step=%b x=%b, expected 1 1", step, x_dir);
    end
    set_ball(1, 4, 2, 0);
    run_period();
    checks++;
    if ({step, x_dir, score_l, score_r} !== {1'b1, 1'b0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL left_hit_edge: step=%b x=%b sl=%0d sr=%0d, expected 1 0 0 0", step, x_dir, score_l, score_r);
    end
  endtask

  task automatic test_left_miss_and_corner();
    set_ball(6, 3, 0, 2);
    run_period();
    set_ball(1, 5, 2, 0);
    repeat (4) tick_clk();
    checks++;
    if ({state, step, score_l, score_r} !== {3'd3, 1'b0, 2'd0, 2'd1}) begin
      errors++;
      $display("FAIL left_miss: state=%0d step=%b sl=%0d sr=%0d, expected 3 0 0 1", state, step, score_l, score_r);
    end
    tick_clk();
    checks++;
    if ({state, x_dir, y_dir, en} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reserve_left: state=%0d x=%b y=%b en=%b, expected 1 1 0 0", state, x_dir, y_dir, en);
    end
    wait_step("reserve_left_step");
    set_ball(4, 7, 0, 0);
    run_period();
    checks++;
    if ({step, x_dir, y_dir} !== 3'b111) begin
      errors++;
      $display("FAIL corner_setup: step=%b x=%b y=%b, expected 1 1 1", step, x_dir, y_dir);
    end
    set_ball(1, 0, 0, 0);
    run_period();
    checks++;
    if ({step, x_dir, y_dir} !== 3'b100) begin
      errors++;
      $display("FAIL corner_hit: step=%b x=%b y=%b, expected 1 0 0", step, x_dir, y_dir);
    end
  endtask

  task automatic test_right_miss();
    set_ball(6, 0, 0, 5);
    repeat (4) tick_clk();
    checks++;
    if ({state, step, score_l, score_r} !== {3'd3, 1'b0, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL right_miss: state=%0d step=%b sl=%0d sr=%0d, expected 3 0 1 1", state, step, score_l, score_r);
    end
    tick_clk();
    checks++;
    if ({state, x_dir, y_dir} !== {3'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reserve_right: state=%0d x=%b y=%b, expected 1 0 0", state, x_dir, y_dir);
    end
    wait_step("reserve_right_step");
  endtask

  task automatic test_game_over();
    int bad = 0;
    set_ball(6, 7, 0, 7);
    run_period();
    checks++;
    if ({step, x_dir, y_dir} !== 3'b111) begin
      errors++;
      $display("FAIL paddle_no_wrap: step=%b x=%b y=%b, expected 1 1 1", step, x_dir, y_dir);
    end
    set_ball(1, 7, 0, 0);
    repeat (4) tick_clk();
    checks++;
    if ({state, score_r} !== {3'd3, 2'd2}) begin
      errors++;
      $display("FAIL miss_two: state=%0d sr=%0d, expected 3 2", state, score_r);
    end
    tick_clk();
    wait_step("serve_three");
    set_ball(1, 3, 4, 0);
    repeat (4) tick_clk();
    checks++;
    if ({state, score_r, step} !== {3'd3, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL miss_win: state=%0d sr=%0d step=%b, expected 3 3 0", state, score_r, step);
    end
    tick_clk();
    checks++;
    if ({state, endgame} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL over_enter: state=%0d endgame=%b, expected 4 1", state, endgame);
    end
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      if ({state, endgame, step, score_l, score_r} !== {3'd4, 1'b1, 1'b0, 2'd1, 2'd3}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL over_hold: %0d bad cycles (last state=%0d step=%b sl=%0d sr=%0d), expected 0", bad, state, step, score_l, score_r);
    end
    start = 1'b1;
    tick_clk();
    checks++;
    if ({state, endgame, score_l, score_r, x_dir} !== {3'd1, 1'b0, 2'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL restart: state=%0d endgame=%b sl=%0d sr=%0d x=%b, expected 1 0 0 0 0", state, endgame, score_l, score_r, x_dir);
    end
    tick_clk();
    start = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL start_in_serve: state=%0d expected 1", state);
    end
    wait_step("restart_step");
    checks++;
    if ({state, en} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL restart_load: state=%0d en=%b, expected 2 0", state, en);
    end
  endtask

  task automatic test_reset_in_play();
    int bad = 0;
    set_ball(6, 3, 0, 2);
    run_period();
    checks++;
    if ({step, x_dir} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_hit: step=%b x=%b, expected 1 1", step, x_dir);
    end
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    checks++;
    if ({state, en} !== {3'd2, 1'b1}) begin
      errors++;
      $display("FAIL start_in_play: state=%0d en=%b, expected 2 1", state, en);
    end
    tick_clk();
    rst = 1'b1;
    tick_clk();
    checks++;
    if ({state, step, en, x_dir, y_dir, score_l, score_r, endgame} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid_play: state=%0d step=%b en=%b x=%b y=%b sl=%0d sr=%0d eg=%b, expected all 0",
               state, step, en, x_dir, y_dir, score_l, score_r, endgame);
    end
    tick_clk();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick_clk();
      if ({state, step} !== {3'd0, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_idle: %0d bad cycles (last state=%0d step=%b), expected 0", bad, state, step);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_ball(4, 3, 0, 0);
    test_reset();
    test_serve();
    test_y_bounce();
    test_left_hit();
    test_left_miss_and_corner();
    test_right_miss();
    test_game_over();
    test_reset_in_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
